// File: rtl/out_sram_req_arbiter_pkg.sv
// out_sram_req_arbiter_pkg
// Shared types and constants for the output-SRAM request path.
// Used by the vertex bank buffers, this arbiter and the output SRAM.
//   Bank_Req2Req_Output_SRAM : per-bank request {req, addr, data}
//   `Num_Vertex_Unit         : number of vertex units (= requesting banks)
// Optional build macro used by the top: OUT_SRAM_PERF_EN.
`ifndef Num_Vertex_Unit
`define Num_Vertex_Unit 4
`endif

package out_sram_req_arbiter_pkg;

  localparam int NUM_BANK_DEF = `Num_Vertex_Unit;
  localparam int ADDR_W       = 10;
  localparam int DATA_W       = 64;
  localparam int CNT_W_DEF    = 16;

  typedef struct packed {
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } Bank_Req2Req_Output_SRAM;

  // Pointer width able to index n banks (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/out_sram_req_arbiter_rr_arbiter.sv
// out_sram_req_arbiter_rr_arbiter
// Combinational round-robin search. Starting at ptr_i and wrapping modulo
// NUM_BANK, the first requesting bank is granted; the returned pointer is the
// bank after the winner, or ptr_i unchanged when nothing is granted.
//   req_i     : request vector, one bit per bank
//   ptr_i     : current round-robin start position
//   en_i      : grant enable (low forces no grant and a held pointer)
//   gnt_o     : one-hot or zero grant
//   ptr_nxt_o : pointer to register at the next edge
module out_sram_req_arbiter_rr_arbiter #(
  parameter int NUM_BANK = 4,
  parameter int PTR_W    = 2
) (
  input  logic [NUM_BANK-1:0] req_i,
  input  logic [PTR_W-1:0]    ptr_i,
  input  logic                en_i,
  output logic [NUM_BANK-1:0] gnt_o,
  output logic [PTR_W-1:0]    ptr_nxt_o
);

  int               pos;
  logic [PTR_W-1:0] sel;
  logic             found;

  always_comb begin
    gnt_o     = '0;
    ptr_nxt_o = ptr_i;
    found     = 1'b0;
    pos       = 0;
    sel       = '0;
    for (int i = 0; i < NUM_BANK; i++) begin
      pos = int'(ptr_i) + i;
      if (pos >= NUM_BANK) pos = pos - NUM_BANK;
      sel = PTR_W'(pos);
      if (en_i && !found && req_i[sel]) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        ptr_nxt_o  = (pos == NUM_BANK - 1) ? '0 : PTR_W'(pos + 1);
      end
    end
  end

endmodule

// File: rtl/out_sram_req_arbiter.sv
// out_sram_req_arbiter
// Round-robin arbiter between the vertex bank buffers and the output SRAM
// write port. One bank is granted per cycle (combinational req_grant), the
// winning address/data is registered one stage and presented to the SRAM,
// committed writes are counted and idle is reported to the layer controller.
//   clk, reset     : clock, asynchronous active-high reset
//   bank_req_pkt   : per-bank {req, addr, data}, held until granted
//   sram_stall     : SRAM busy, suppresses all grants
//   cnt_clear      : synchronous clear of wr_count (wins over increment)
//   req_grant      : one-hot or zero grant, same cycle as the request
//   sram_wr_en/addr/data : registered SRAM write port
//   wr_count       : writes committed since reset or cnt_clear
//   idle           : no request pending and write stage empty
//   stall_cycles   : per-bank waiting-cycle counters (OUT_SRAM_PERF_EN only)
// Build macro: OUT_SRAM_PERF_EN adds saturating per-bank stall counters.
module out_sram_req_arbiter
  import out_sram_req_arbiter_pkg::*;
#(
  parameter int NUM_BANK = NUM_BANK_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  Bank_Req2Req_Output_SRAM bank_req_pkt [NUM_BANK],
  input  logic                    sram_stall,
  input  logic                    cnt_clear,
  output logic [NUM_BANK-1:0]     req_grant,
  output logic                    sram_wr_en,
  output logic [ADDR_W-1:0]       sram_wr_addr,
  output logic [DATA_W-1:0]       sram_wr_data,
  output logic [CNT_W-1:0]        wr_count,
  output logic                    idle
`ifdef OUT_SRAM_PERF_EN
  ,
  output logic [CNT_W-1:0]        stall_cycles [NUM_BANK]
`endif
);

  localparam int PTR_W = ptr_width(NUM_BANK);

  logic [NUM_BANK-1:0] req_vec;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [CNT_W-1:0]    wr_count_q, wr_count_d;

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_req
    assign req_vec[b] = bank_req_pkt[b].req;
  end

  // Grants are suppressed during reset so req_grant reads zero while it is held.
  out_sram_req_arbiter_rr_arbiter #(
    .NUM_BANK (NUM_BANK),
    .PTR_W    (PTR_W)
  ) u_rr_arbiter (
    .req_i     (req_vec),
    .ptr_i     (rr_ptr_q),
    .en_i      (~sram_stall & ~reset),
    .gnt_o     (req_grant),
    .ptr_nxt_o (rr_ptr_d)
  );

  // One-hot AND-OR select of the winner; address/data hold when nothing wins.
  always_comb begin
    wr_en_d   = |req_grant;
    wr_addr_d = '0;
    wr_data_d = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      wr_addr_d = wr_addr_d | (bank_req_pkt[b].addr & {ADDR_W{req_grant[b]}});
      wr_data_d = wr_data_d | (bank_req_pkt[b].data & {DATA_W{req_grant[b]}});
    end
    if (!wr_en_d) begin
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
  end

  // A write is counted on the edge after it was presented; clear has priority.
  always_comb begin
    wr_count_d = wr_count_q;
    if (cnt_clear)    wr_count_d = '0;
    else if (wr_en_q) wr_count_d = wr_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign sram_wr_en   = wr_en_q;
  assign sram_wr_addr = wr_addr_q;
  assign sram_wr_data = wr_data_q;
  assign wr_count     = wr_count_q;
  assign idle         = ~(|req_vec) & ~wr_en_q;

`ifdef OUT_SRAM_PERF_EN
  logic [CNT_W-1:0] stall_q [NUM_BANK];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANK; b++) stall_q[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        if (cnt_clear)
          stall_q[b] <= '0;
        else if (req_vec[b] && !req_grant[b] && (stall_q[b] != '1))
          stall_q[b] <= stall_q[b] + 1'b1;
      end
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
